// File: rtl/receipt_serializer.sv
// receipt_serializer: captures one execution receipt record per handshake and
// emits it as a canonical big-endian byte frame on a valid/ready byte stream.
// Frame: version, length (18), pc, opcode, op_a, op_b, mu_delta, status.
// Optional feature macro RECEIPT_SER_CRC_EN appends a CRC-8 byte (poly 0x07).
//
// Handshake semantics: a transfer happens on a rising clk edge where both
// valid and ready are high; valid never depends on ready, and once valid is
// raised the presented data holds stable until the transfer completes.
module receipt_serializer #(
   parameter logic [7:0] FORMAT_VERSION = 8'h01,
   parameter int         FRAME_CNT_W    = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   rec_valid,
   output logic                   rec_ready,
   input  logic [31:0]            rec_pc,
   input  logic [7:0]             rec_opcode,
   input  logic [31:0]            rec_op_a,
   input  logic [31:0]            rec_op_b,
   input  logic [31:0]            rec_mu_delta,
   input  logic [7:0]             rec_status,
   output logic [7:0]             out_byte,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_last,
   output logic                   busy,
   output logic [FRAME_CNT_W-1:0] frames_out
);

   localparam logic [4:0] LAST_IDX = 5'd19;
`ifdef RECEIPT_SER_CRC_EN
   localparam logic [4:0] FINAL_IDX = 5'd20;
`else
   localparam logic [4:0] FINAL_IDX = 5'd19;
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EMIT = 2'd1,
      CRC  = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [4:0]  idx;
   logic [4:0]  idx_inc;
   logic [7:0]  next_byte;
   logic        accept;
   logic        hs;
   logic [31:0] cap_pc;
   logic [7:0]  cap_opcode;
   logic [31:0] cap_op_a;
   logic [31:0] cap_op_b;
   logic [31:0] cap_mu_delta;
   logic [7:0]  cap_status;

   assign accept  = (state == IDLE) && rec_valid;
   assign hs      = out_valid && out_ready;
   assign idx_inc = idx + 5'd1;

`ifdef RECEIPT_SER_CRC_EN
   logic [7:0] crc;
   logic [7:0] crc_nxt;

   function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
      logic [7:0] r;
      r = c ^ d;
      for (int i = 0; i < 8; i++) begin
         r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
      end
      return r;
   endfunction

   assign crc_nxt = crc8_step(crc, out_byte);

   // CRC accumulates every transferred byte of the frame; cleared on accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc <= 8'h00;
      end else if (accept) begin
         crc <= 8'h00;
      end else if (hs) begin
         crc <= crc_nxt;
      end
   end
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: IDLE -> EMIT on accept, back to IDLE after the final byte
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (rec_valid) state_nxt = EMIT;
`ifdef RECEIPT_SER_CRC_EN
         EMIT: if (hs && (idx == LAST_IDX)) state_nxt = CRC;
         CRC:  if (hs) state_nxt = IDLE;
`else
         EMIT: if (hs && (idx == LAST_IDX)) state_nxt = IDLE;
`endif
         default: state_nxt = IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      rec_ready = (state == IDLE);
      out_valid = (state != IDLE);
      busy      = (state != IDLE);
   end

   // Byte selected for the index about to be presented
   always_comb begin
      next_byte = 8'h00;
      case (idx_inc)
         5'd1:  next_byte = 8'h12;
         5'd2:  next_byte = cap_pc[31:24];
         5'd3:  next_byte = cap_pc[23:16];
         5'd4:  next_byte = cap_pc[15:8];
         5'd5:  next_byte = cap_pc[7:0];
         5'd6:  next_byte = cap_opcode;
         5'd7:  next_byte = cap_op_a[31:24];
         5'd8:  next_byte = cap_op_a[23:16];
         5'd9:  next_byte = cap_op_a[15:8];
         5'd10: next_byte = cap_op_a[7:0];
         5'd11: next_byte = cap_op_b[31:24];
         5'd12: next_byte = cap_op_b[23:16];
         5'd13: next_byte = cap_op_b[15:8];
         5'd14: next_byte = cap_op_b[7:0];
         5'd15: next_byte = cap_mu_delta[31:24];
         5'd16: next_byte = cap_mu_delta[23:16];
         5'd17: next_byte = cap_mu_delta[15:8];
         5'd18: next_byte = cap_mu_delta[7:0];
         5'd19: next_byte = cap_status;
         default: next_byte = 8'h00;
      endcase
   end

   // Capture register, byte index and registered byte/last outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_pc       <= 32'h0;
         cap_opcode   <= 8'h0;
         cap_op_a     <= 32'h0;
         cap_op_b     <= 32'h0;
         cap_mu_delta <= 32'h0;
         cap_status   <= 8'h0;
         idx          <= 5'd0;
         out_byte     <= 8'h00;
         out_last     <= 1'b0;
      end else if (accept) begin
         cap_pc       <= rec_pc;
         cap_opcode   <= rec_opcode;
         cap_op_a     <= rec_op_a;
         cap_op_b     <= rec_op_b;
         cap_mu_delta <= rec_mu_delta;
         cap_status   <= rec_status;
         idx          <= 5'd0;
         out_byte     <= FORMAT_VERSION;
         out_last     <= 1'b0;
      end else if (hs) begin
         if (out_last) begin
            idx      <= 5'd0;
            out_byte <= 8'h00;
            out_last <= 1'b0;
         end else begin
            idx      <= idx_inc;
`ifdef RECEIPT_SER_CRC_EN
            out_byte <= (idx == LAST_IDX) ? crc_nxt : next_byte;
`else
            out_byte <= next_byte;
`endif
            out_last <= (idx_inc == FINAL_IDX);
         end
      end
   end

   // Completed-frame counter, wraps naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frames_out <= '0;
      end else if (hs && out_last) begin
         frames_out <= frames_out + {{(FRAME_CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_receipt_serializer.sv
// Directed testbench for receipt_serializer (4-bit frame counter build).
// Honours RECEIPT_SER_CRC_EN to expect the 21-byte framing.
module tb_receipt_serializer;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          rec_valid = 1'b0;
   logic          rec_ready;
   logic [31:0]   rec_pc = '0;
   logic [7:0]    rec_opcode = '0;
   logic [31:0]   rec_op_a = '0;
   logic [31:0]   rec_op_b = '0;
   logic [31:0]   rec_mu_delta = '0;
   logic [7:0]    rec_status = '0;
   logic [7:0]    out_byte;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic          out_last;
   logic          busy;
   logic [CW-1:0] frames_out;

   int total = 0;
   int bad   = 0;

   logic [7:0] exp_q[$];

   logic [7:0] vec_a [20] = '{8'h01, 8'h12, 8'h00, 8'h00, 8'h10, 8'h00, 8'h2A, 8'hDE, 8'hAD, 8'hBE,
                              8'hEF, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h10, 8'h80};
   logic [7:0] vec_b [20] = '{8'h01, 8'h12, 8'h00, 8'h00, 8'h20, 8'h04, 8'h11, 8'h01, 8'h02, 8'h03,
                              8'h04, 8'hA5, 8'hA5, 8'h5A, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h03, 8'h01};
   logic [7:0] vec_z [20] = '{8'h01, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

   receipt_serializer #(
      .FORMAT_VERSION (8'h01),
      .FRAME_CNT_W    (CW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rec_valid    (rec_valid),
      .rec_ready    (rec_ready),
      .rec_pc       (rec_pc),
      .rec_opcode   (rec_opcode),
      .rec_op_a     (rec_op_a),
      .rec_op_b     (rec_op_b),
      .rec_mu_delta (rec_mu_delta),
      .rec_status   (rec_status),
      .out_byte     (out_byte),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_last     (out_last),
      .busy         (busy),
      .frames_out   (frames_out)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] crc8_model(input logic [7:0] v [20]);
      logic [7:0] c;
      c = 8'h00;
      for (int i = 0; i < 20; i++) begin
         c = c ^ v[i];
         for (int b = 0; b < 8; b++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
      end
      return c;
   endfunction

   task automatic load_exp(input logic [7:0] v [20], input bit zero_rec);
      exp_q.delete();
      for (int i = 0; i < 20; i++) exp_q.push_back(v[i]);
`ifdef RECEIPT_SER_CRC_EN
      exp_q.push_back(zero_rec ? 8'hC4 : crc8_model(v));
`else
      if (zero_rec) exp_q.push_back(8'h00);
      if (zero_rec) void'(exp_q.pop_back());
`endif
   endtask

   task automatic set_rec(input logic [31:0] pc, input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] mu, input logic [7:0] st);
      rec_pc = pc; rec_opcode = op; rec_op_a = a; rec_op_b = b; rec_mu_delta = mu; rec_status = st;
   endtask

   task automatic set_rec_a();
      set_rec(32'h0000_1000, 8'h2A, 32'hDEAD_BEEF, 32'h0000_0001, 32'h0000_0010, 8'h80);
   endtask

   task automatic set_rec_b();
      set_rec(32'h0000_2004, 8'h11, 32'h0102_0304, 32'hA5A5_5A5A, 32'h0000_0003, 8'h01);
   endtask

   // Driver: offer the current record for one cycle; called at posedge+1
   task automatic accept_rec(input string tag);
      rec_valid = 1'b1;
      chk({tag, "_rec_ready_idle"}, rec_ready, 1);
      @(posedge clk); #1;
      rec_valid = 1'b0;
      chk({tag, "_latency_valid"}, out_valid, 1);
      chk({tag, "_rec_ready_low"}, rec_ready, 0);
   endtask

   // Scoreboard sink: consumes exp_q, optionally stalling; called at posedge+1
   task automatic drain(input string tag, input bit stall);
      int         cyc;
      logic [7:0] prev_b;
      logic       prev_l;
      bit         prev_stall;
      logic       r;
      cyc = 0; prev_stall = 0; prev_b = 8'h00; prev_l = 1'b0;
      while (exp_q.size() > 0 && cyc < 200) begin
         chk({tag, "_valid"}, out_valid, 1);
         if (out_valid) begin
            if (prev_stall) begin
               chk({tag, "_stall_byte"}, out_byte, prev_b);
               chk({tag, "_stall_last"}, out_last, prev_l);
            end
            chk({tag, "_byte"}, out_byte, exp_q[0]);
            chk({tag, "_last"}, out_last, (exp_q.size() == 1) ? 1 : 0);
            chk({tag, "_busy"}, busy, 1);
            chk({tag, "_rec_ready"}, rec_ready, 0);
            if (stall) r = (cyc % 3 == 1) ? 1'b0 : 1'($urandom_range(0, 1));
            else       r = 1'b1;
            out_ready  = r;
            prev_b     = out_byte;
            prev_l     = out_last;
            prev_stall = !r;
            if (r) void'(exp_q.pop_front());
         end
         @(posedge clk); #1;
         cyc++;
      end
      out_ready = 1'b1;
      chk({tag, "_bytes_left"}, exp_q.size(), 0);
      chk({tag, "_valid_falls"}, out_valid, 0);
      chk({tag, "_busy_falls"}, busy, 0);
      chk({tag, "_last_falls"}, out_last, 0);
   endtask

   initial begin
      // reset
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rec_ready", rec_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_byte", out_byte, 0);
      chk("rst_frames", frames_out, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: full-rate frame
      set_rec_a();
      accept_rec("t1");
      load_exp(vec_a, 0);
      drain("t1", 0);
      chk("t1_frames", frames_out, 1);
      chk("t1_rec_ready_back", rec_ready, 1);

      // 2: same record with pseudo-random stalls
      accept_rec("t2");
      load_exp(vec_a, 0);
      drain("t2", 1);
      chk("t2_frames", frames_out, 2);

      // 3: rec_valid held, second record queued; inputs change mid-frame
      set_rec_a();
      rec_valid = 1'b1;
      @(posedge clk); #1;
      set_rec_b();
      load_exp(vec_a, 0);
      drain("t3a", 0);
      chk("t3_gap_rec_ready", rec_ready, 1);
      @(posedge clk); #1;
      chk("t3_b2b_valid", out_valid, 1);
      chk("t3_b2b_byte0", out_byte, 8'h01);
      rec_valid = 1'b0;
      load_exp(vec_b, 0);
      drain("t3b", 0);
      chk("t3_frames", frames_out, 4);

      // 4: async reset while index 7 is stalled
      set_rec_a();
      accept_rec("t4");
      repeat (7) begin @(posedge clk); #1; end
      out_ready = 1'b0;
      chk("t4_idx7_byte", out_byte, 8'hDE);
      repeat (2) begin @(posedge clk); #1; end
      chk("t4_idx7_hold", out_byte, 8'hDE);
      rst_n = 1'b0;
      #1;
      chk("t4_rst_valid", out_valid, 0);
      chk("t4_rst_busy", busy, 0);
      chk("t4_rst_rec_ready", rec_ready, 1);
      chk("t4_rst_frames", frames_out, 0);
      chk("t4_rst_last", out_last, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      set_rec_b();
      accept_rec("t4b");
      chk("t4b_byte0", out_byte, 8'h01);
      load_exp(vec_b, 0);
      drain("t4b", 0);
      chk("t4_frames", frames_out, 1);

      // 5: all-zero record (CRC byte C4 when the CRC build is used)
      set_rec(32'h0, 8'h0, 32'h0, 32'h0, 32'h0, 8'h0);
      accept_rec("t5");
      load_exp(vec_z, 1);
      drain("t5", 0);
      chk("t5_frames", frames_out, 2);

      // 6: counter wrap over 17 frames from reset
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      set_rec_a();
      for (int f = 1; f <= 17; f++) begin
         accept_rec("t6");
         load_exp(vec_a, 0);
         drain("t6", 0);
         if (f == 15) chk("t6_frames_f", frames_out, 4'hF);
         if (f == 16) chk("t6_frames_wrap", frames_out, 4'h0);
      end
      chk("t6_frames_final", frames_out, 4'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
